uart_trx: RTL and testbench

UART transmitter/receiver pair: `uart_tx` serialises bytes onto a line and `uart_rx` deserialises bytes from a line, both paced by a shared external one-per-bit `baud_tick`. It sits between the board-level serial pins and the byte-level datapath and supports FPGA-to-FPGA links. The wrapper instantiates one `uart_tx` and one `uart_rx`, which can be looped back (`tx` to `rx`) for self-test. Frame format is 8N1: 8 data bits, LSB first, one stop bit, with optional parity.

---
 rtl/uart_trx.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_uart_trx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_trx.sv
// uart_trx: 8N1 UART transmitter/receiver pair paced by a shared one-per-bit
// baud_tick. The wrapper holds one uart_tx and one uart_rx. The tx output and
// the rx input are separate pins, so a loopback is made outside the block.
//
// Optional feature macro: UART_PARITY_EN
//   When it is defined, TX sends an even-parity bit after data bit 7.
//   RX checks that bit and reports a mismatch on rx_parity_err.
//   When it is undefined (the default), the frame is plain 8N1 and the
//   rx_parity_err port does not exist.
//
// Handshake: a transfer is accepted on any clk where start=1 and the
// transmitter is idle (tx_busy=0). tx_busy reads 1 from the next clk until the
// frame ends, and start is ignored while tx_busy=1. rx_valid, rx_frame_err and
// rx_parity_err are single-clk pulses with no backpressure; rx_data holds the
// last good byte.
//
// Reset: rst is asynchronous and active-low. It aborts any frame in flight.

// ---------------------------------------------------------------------------
// Transmitter
// ---------------------------------------------------------------------------
module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_WAIT   = 3'd1,
        TX_START  = 3'd2,
        TX_DATA   = 3'd3,
        TX_PARITY = 3'd4,
        TX_STOP   = 3'd5
    } tx_state_t;

    tx_state_t  state;
    logic [7:0] data_q;
    logic [2:0] bit_idx;
    logic [2:0] next_idx;

    assign next_idx  = bit_idx + 3'd1;
    assign state_dbg = state;

    // Frame sequencer. Each state holds its line level for one tick period.
    // WAIT aligns the start bit to the first tick after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= TX_IDLE;
            data_q  <= 8'h00;
            bit_idx <= 3'd0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        data_q  <= tx_data;
                        bit_idx <= 3'd0;
                        tx_busy <= 1'b1;
                        state   <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (baud_tick) begin
                        tx    <= 1'b0;
                        state <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_tick) begin
                        tx      <= data_q[0];
                        bit_idx <= 3'd0;
                        state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx    <= ^data_q;
                            state <= TX_PARITY;
`else
                            tx    <= 1'b1;
                            state <= TX_STOP;
`endif
                        end else begin
                            tx      <= data_q[next_idx];
                            bit_idx <= next_idx;
                        end
                    end
                end
                TX_PARITY: begin
                    if (baud_tick) begin
                        tx    <= 1'b1;
                        state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    // The line stays high; it becomes the idle level.
                    if (baud_tick) begin
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                        bit_idx <= 3'd0;
                        state   <= TX_IDLE;
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// ---------------------------------------------------------------------------
// Receiver
// ---------------------------------------------------------------------------
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
`ifdef UART_PARITY_EN
    output logic       rx_parity_err,
`endif
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    rx_state_t  state;
    logic       rx_meta;
    logic       rx_sync;
    logic [7:0] shift_q;
    logic [2:0] bit_idx;
`ifdef UART_PARITY_EN
    logic       par_q;
`endif

    assign state_dbg = state;

    // Two-flop synchronizer. It resets to the idle (high) level so that a
    // reset is never taken as a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Frame sampler. It looks at the line only on baud_tick. The status
    // outputs are one-clk pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RX_IDLE;
            shift_q      <= 8'h00;
            bit_idx      <= 3'd0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            par_q         <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            case (state)
                RX_IDLE: begin
                    if (baud_tick && !rx_sync) begin
                        bit_idx <= 3'd0;
                        state   <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (baud_tick) begin
                        // LSB arrives first, so shift in from the top.
                        shift_q <= {rx_sync, shift_q[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= RX_PARITY;
`else
                            state <= RX_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (baud_tick) begin
`ifdef UART_PARITY_EN
                        par_q <= rx_sync;
`endif
                        state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (baud_tick) begin
                        if (rx_sync) begin
`ifdef UART_PARITY_EN
                            if (par_q != ^shift_q) begin
                                rx_parity_err <= 1'b1;
                            end else begin
                                rx_data  <= shift_q;
                                rx_valid <= 1'b1;
                            end
`else
                            rx_data  <= shift_q;
                            rx_valid <= 1'b1;
`endif
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                        bit_idx <= 3'd0;
                        state   <= RX_IDLE;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// ---------------------------------------------------------------------------
// Wrapper
// ---------------------------------------------------------------------------
module uart_trx (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
`ifdef UART_PARITY_EN
    output logic       rx_parity_err,
`endif
    output logic [2:0] tx_state_dbg,
    output logic [1:0] rx_state_dbg
);

    uart_tx u_tx (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .start     (start),
        .tx_data   (tx_data),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .state_dbg (tx_state_dbg)
    );

    uart_rx u_rx (
        .clk           (clk),
        .rst           (rst),
        .baud_tick     (baud_tick),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
`ifdef UART_PARITY_EN
        .rx_parity_err (rx_parity_err),
`endif
        .state_dbg     (rx_state_dbg)
    );

endmodule

// File: tb/tb_uart_trx.sv
// tb_uart_trx: scoreboard bench for uart_trx. Expected RX responses are queued
// when stimulus is issued. A monitor pops and compares them whenever the DUT
// pulses rx_valid, rx_frame_err or rx_parity_err. The build follows
// UART_PARITY_EN, just as the design does.
module tb_uart_trx;

    localparam int TICK_DIV = 16;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int W = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       perr;
    logic [2:0] tx_state_dbg;
    logic [1:0] rx_state_dbg;
    logic       loopback;
    logic       rx_drv;
    int         tick_cnt = 0;

    int checks = 0;
    int failures = 0;
    // Response word: {parity_err, frame_err, valid, rx_data}
    logic [W-1:0] exp_q[$];
    logic [7:0]   exp_rx_data;

`ifdef UART_PARITY_EN
    logic rx_parity_err;
    assign perr = rx_parity_err;
`else
    assign perr = 1'b0;
`endif

    assign rx = loopback ? tx : rx_drv;

    uart_trx dut (
        .clk           (clk),
        .rst           (rst),
        .baud_tick     (baud_tick),
        .start         (start),
        .tx_data       (tx_data),
        .tx            (tx),
        .tx_busy       (tx_busy),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
`ifdef UART_PARITY_EN
        .rx_parity_err (rx_parity_err),
`endif
        .tx_state_dbg  (tx_state_dbg),
        .rx_state_dbg  (rx_state_dbg)
    );

    // ---------------- clock / reset / tick ----------------
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (tick_cnt == TICK_DIV - 1) tick_cnt = 0;
        else tick_cnt = tick_cnt + 1;
        baud_tick = (tick_cnt == 0);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        @(posedge clk);
        while (!baud_tick && n < 2 * TICK_DIV) begin
            @(posedge clk);
            n++;
        end
        check("tick_wait", 32'(baud_tick), 32'd1);
        #1;
    endtask

    // Sends one byte over the loopback and checks the line waveform and timing.
    task automatic send_byte(input logic [7:0] b);
        int n;
        logic [FRAME_BITS-1:0] frame;
        logic [FRAME_BITS-1:0] exp_frame;
        n = 0;
        while (tx_busy && n < 2 * FRAME_BITS * TICK_DIV) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(tx_busy), 32'd0);
`ifdef UART_PARITY_EN
        exp_frame = {1'b1, ^b, b, 1'b0};
`else
        exp_frame = {1'b1, b, 1'b0};
`endif
        exp_q.push_back({3'b001, b});
        exp_rx_data = b;
        start = 1'b1;
        tx_data = b;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", 32'(tx_busy), 32'd1);
        check("tx_high_in_wait", 32'(tx), 32'd1);
        n = 0;
        while (tx && n < 2 * TICK_DIV + 4) begin
            @(negedge clk);
            n++;
        end
        check("start_bit_seen", 32'(tx), 32'd0);
        frame = '0;
        n = 0;
        while (tx_busy && n < 2 * FRAME_BITS * TICK_DIV) begin
            if ((n % TICK_DIV) == TICK_DIV / 2 && (n / TICK_DIV) < FRAME_BITS)
                frame[n / TICK_DIV] = tx;
            @(negedge clk);
            n++;
        end
        check("frame_len", 32'(n), 32'(FRAME_BITS * TICK_DIV));
        check("frame_bits", 32'(frame), 32'(exp_frame));
    endtask

    // Drives a frame directly onto rx; f[0] is the start bit.
    task automatic drive_rx_frame(input logic [FRAME_BITS-1:0] f);
        for (int i = 0; i < FRAME_BITS; i++) begin
            wait_tick();
            rx_drv = f[i];
        end
        wait_tick();
        rx_drv = 1'b1;
        @(negedge clk);
    endtask

    // Scoreboard monitor: pops one expected response per reported pulse.
    task automatic monitor();
        logic         busy_prev;
        logic [W-1:0] got;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            got = {perr, rx_frame_err, rx_valid, rx_data};
            if (rx_valid || rx_frame_err || perr) begin
                if (exp_q.size() == 0) check("unexpected_resp", 32'(got), 32'd0);
                else check("rx_resp", 32'(got), 32'(exp_q.pop_front()));
                if (rx_valid && loopback)
                    check("valid_at_busy_fall", 32'({busy_prev, tx_busy}), 32'b10);
            end
            busy_prev = tx_busy;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        start = 1'b0;
        tx_data = 8'h00;
        rx_drv = 1'b1;
        loopback = 1'b1;
        exp_rx_data = 8'h00;
        #5 rst = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_frame_err", 32'(rx_frame_err), 32'd0);
        check("rst_tx_state", 32'(tx_state_dbg), 32'd0);
        check("rst_rx_state", 32'(rx_state_dbg), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA5, with a 0x3C start pulse mid-frame that must be ignored
        fork
            send_byte(8'hA5);
            begin
                repeat (5 * TICK_DIV) @(negedge clk);
                start = 1'b1;
                tx_data = 8'h3C;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check("rx_data_a5", 32'(rx_data), 32'hA5);

        // Back-to-back frames
        send_byte(8'h00);
        send_byte(8'hFF);
        check("rx_data_ff", 32'(rx_data), 32'hFF);

        // Framing error: 0x55 with the stop bit low
        repeat (TICK_DIV) @(negedge clk);
        loopback = 1'b0;
        exp_q.push_back({3'b010, exp_rx_data});
`ifdef UART_PARITY_EN
        drive_rx_frame({1'b0, 1'b0, 8'h55, 1'b0});
`else
        drive_rx_frame({1'b0, 8'h55, 1'b0});
`endif
        repeat (4) @(negedge clk);
        check("rx_data_after_ferr", 32'(rx_data), 32'(exp_rx_data));
        repeat (2 * TICK_DIV) @(negedge clk);
        loopback = 1'b1;

`ifdef UART_PARITY_EN
        // Parity: 0x07 carries a parity bit of 1; then inject a flipped one
        send_byte(8'h07);
        repeat (TICK_DIV) @(negedge clk);
        loopback = 1'b0;
        exp_q.push_back({3'b100, exp_rx_data});
        drive_rx_frame({1'b1, 1'b0, 8'h07, 1'b0});
        repeat (4) @(negedge clk);
        check("rx_data_after_perr", 32'(rx_data), 32'h07);
        repeat (2 * TICK_DIV) @(negedge clk);
        loopback = 1'b1;
`endif

        // Mid-frame reset during data bit 4
        start = 1'b1;
        tx_data = 8'h42;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (tx && n < 2 * TICK_DIV + 4) begin
            @(negedge clk);
            n++;
        end
        check("reset_frame_started", 32'(tx), 32'd0);
        repeat (5 * TICK_DIV + TICK_DIV / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        exp_rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h81);
        check("rx_data_81", 32'(rx_data), 32'h81);

        repeat (2 * TICK_DIV) @(negedge clk);
        check("missing_resp", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
